// File: rtl/uart_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_defs (package)
// Description : Shared UART definitions: receiver FSM encoding, parity mode
//               constants and the baud-divider derivation used by both the
//               receiver and the transmitter.
// Revision    : 1.0 - initial configurable-receiver release
// ============================================================================
package uart_defs;

  // Receiver FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Parity mode encoding
  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  // Clock cycles per bit (integer division, no fractional correction)
  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Mid-bit count around which the majority samples are taken
  function automatic int calc_half(input int baud_div);
    return baud_div / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter. Counts 0..BAUD_DIV-1 while enabled and
//               strobes the three mid-bit sample points and the bit boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int BAUD_DIV = 520
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic mid_m1,
  output logic mid,
  output logic mid_p1,
  output logic wrap
);
  import uart_defs::*;

  localparam int                CNT_W = $clog2(BAUD_DIV);
  localparam int                HALF  = calc_half(BAUD_DIV);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  C_M1   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  C_MID  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]  C_P1   = CNT_W'(HALF + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, otherwise wrap at the end of the bit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Decode strobes from the current count
  always_comb begin
    mid_m1 = en && (cnt_q == C_M1);
    mid    = en && (cnt_q == C_MID);
    mid_p1 = en && (cnt_q == C_P1);
    wrap   = en && (cnt_q == C_LAST);
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Configurable UART receiver (5..9 data bits, optional even/odd
//               parity, 1 or 2 stop bits) with 3-sample mid-bit majority vote
//               and parity/framing error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 5_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  import uart_defs::*;

  localparam int         BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  // Synchroniser and edge history
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_hist_q, rx_hist_d;

  // FSM and datapath state
  rx_state_e            state_q, state_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 samp0_q, samp0_d;
  logic                 samp1_q, samp1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;

  // Output registers
  logic [DATA_BITS-1:0] po_data_q, po_data_d;
  logic                 po_flag_q, po_flag_d;
  logic                 po_perr_q, po_perr_d;
  logic                 po_ferr_q, po_ferr_d;

  logic start_edge;
  logic vote;
  logic exp_par;
  logic last_data;
  logic last_stop;
  logic frame_done;
  logic cnt_clr;
  logic mid_m1, mid, mid_p1, wrap;

  // Counter idles cleared so every frame starts its START bit at count 0
  uart_baud_cnt #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (busy),
    .mid_m1 (mid_m1),
    .mid    (mid),
    .mid_p1 (mid_p1),
    .wrap   (wrap)
  );

  // Combinational helpers shared by the FSM and datapath
  always_comb begin
    start_edge = rx_hist_q & ~rx_sync_q;
    vote       = (samp0_q & samp1_q) | (samp0_q & rx_sync_q) | (samp1_q & rx_sync_q);
    exp_par    = (^shift_q) ^ PAR_ODD;
    last_data  = (bit_idx_q == LAST_DATA);
    last_stop  = (bit_idx_q == LAST_STOP);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; the last stop bit exits at its decision point
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) state_d = ST_START;
      end
      ST_START: begin
        if (mid_p1 && vote) state_d = ST_IDLE;
        else if (wrap)      state_d = ST_DATA;
      end
      ST_DATA: begin
        if (wrap && last_data) state_d = PAR_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (mid_p1 && last_stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != ST_IDLE);
    cnt_clr    = (state_q == ST_IDLE);
    frame_done = (state_q == ST_STOP) && mid_p1 && last_stop;
  end

  // Synchroniser next values
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_hist_d = rx_sync_q;
  end

  // Synchroniser registers; idle-high so reset never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_hist_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_hist_q <= rx_hist_d;
    end
  end

  // Datapath: samples, bit index, shift register, error flags and outputs
  always_comb begin
    samp0_d   = samp0_q;
    samp1_d   = samp1_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    po_data_d = po_data_q;
    po_perr_d = po_perr_q;
    po_ferr_d = po_ferr_q;
    po_flag_d = 1'b0;

    if (mid_m1) samp0_d = rx_sync_q;
    if (mid)    samp1_d = rx_sync_q;

    // Index restarts in every state so it serves both data and stop bits
    if (state_d != state_q) begin
      bit_idx_d = '0;
    end else if (wrap && (state_q == ST_DATA || state_q == ST_STOP)) begin
      bit_idx_d = bit_idx_q + 1'b1;
    end

    if (state_q == ST_IDLE && start_edge) begin
      par_err_d = 1'b0;
      frm_err_d = 1'b0;
    end

    if (state_q == ST_DATA && mid_p1) begin
      shift_d = {vote, shift_q[DATA_BITS-1:1]};
    end

    if (state_q == ST_PARITY && mid_p1 && (vote != exp_par)) begin
      par_err_d = 1'b1;
    end

    if (state_q == ST_STOP && mid_p1 && !vote) begin
      frm_err_d = 1'b1;
    end

    // Include the final stop decision, which is not yet in frm_err_q
    if (frame_done) begin
      po_flag_d = 1'b1;
      po_data_d = shift_q;
      po_perr_d = par_err_q;
      po_ferr_d = frm_err_q | ~vote;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp0_q   <= 1'b1;
      samp1_q   <= 1'b1;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      po_data_q <= '0;
      po_flag_q <= 1'b0;
      po_perr_q <= 1'b0;
      po_ferr_q <= 1'b0;
    end else begin
      samp0_q   <= samp0_d;
      samp1_q   <= samp1_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      po_data_q <= po_data_d;
      po_flag_q <= po_flag_d;
      po_perr_q <= po_perr_d;
      po_ferr_q <= po_ferr_d;
    end
  end

  // Port drivers
  always_comb begin
    po_data    = po_data_q;
    po_flag    = po_flag_q;
    parity_err = po_perr_q;
    frame_err  = po_ferr_q;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Configurable UART receiver, the successor to the fixed 8N1 receiver. It supports 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits. Each bit is decided by a mid-bit majority vote of three samples, and the block reports parity and framing errors. It sits between the board-level `rx` pin and the protocol/FIFO logic, and delivers one word per frame with a single-cycle valid strobe.

## Interface
- `CLK_FREQ`, 5_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate.
  - `BAUD_DIV = CLK_FREQ/BAUD_RATE` (integer division).
  - `HALF = BAUD_DIV/2`.
- `DATA_BITS`, 8: data word width, legal range 5..9.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN=0`.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx`  input  1  serial line. Asynchronous to `clk`; idles high.
- `po_data`  output  DATA_BITS  received word, LSB received first.
- `po_flag`  output  1  one-cycle strobe: `po_data` and the error flags are valid.
- `parity_err`  output  1  parity mismatch on this frame. Valid only with `po_flag`.
- `frame_err`  output  1  a stop bit was sampled low. Valid only with `po_flag`.
- `busy`  output  1  high from start-edge detection until the frame ends or is aborted.

## Operation
- Input synchronisation:
  - `rx` passes through a 2-flop synchroniser plus one history flop. All three reset to 1.
  - A start edge is history=1 and sync=0.
- Baud counter:
  - Width is `$clog2(BAUD_DIV)`.
  - Clears on entering START and at each bit boundary.
  - Wraps at `BAUD_DIV-1`.
- Sampling: the synced line is captured at counts `HALF-1`, `HALF` and `HALF+1`. The bit value is the majority of the three, decided at `HALF+1`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a start edge.
  - START: if the voted bit is 1, the start is false → IDLE, with no `po_flag`. If 0, wait until the count wraps, then → DATA.
  - DATA: shift the voted bit into the MSB of the shift register (LSB-first line order). The bit index counts 0..`DATA_BITS-1`. After the last bit → PARITY if `PARITY_EN`, else STOP.
  - PARITY: compute XOR of the data bits, XOR-ed with `PARITY_ODD`. Compare it with the voted bit; a mismatch latches the internal parity error. → STOP.
  - STOP: every stop bit sampled low sets the internal frame error. At the decision point of the last stop bit, go → IDLE immediately, without waiting for the end of the bit period, so that a back-to-back start edge is caught.
- Frame completion:
  - The cycle after the last stop decision, `po_flag`=1.
  - `po_data` is loaded with the shift register.
  - `parity_err` and `frame_err` are loaded with the internal error flags.
- A completed frame always produces `po_flag`, even when errors are set.
  - A break (all bits low) produces `po_data`=0 and `frame_err`=1.
  - After a frame error, the line must return high before the next start edge can be detected.
- Reset values:
  - `po_data`=0, `po_flag`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - FSM in IDLE, counters at 0, internal error flags at 0.
- `po_data`, `parity_err` and `frame_err` hold their values until the next `po_flag`.

## Timing
- Synchroniser latency: 2 cycles from a pin edge to the sync flop, plus 1 cycle to edge detection.
- Latency from the start edge to `po_flag`:
  - `(1 + DATA_BITS + PARITY_EN + STOP_BITS - 1) × BAUD_DIV + HALF + 2` cycles after detection. This is ±1 cycle with respect to the pin edge because of synchroniser phase.
- `busy` rises in the cycle after edge detection. It falls in the same cycle that `po_flag` rises, or 1 cycle after a false start.
- `po_flag` is exactly one cycle wide. No back-pressure: the consumer must accept the word in that cycle.
- Reset asserted mid-frame: all state clears asynchronously and no partial `po_flag` is produced. After release, the receiver needs a fresh high→low edge before it starts a new frame.
- Data rate tolerance: the majority window spans 3 cycles around `HALF`. No fractional baud correction is applied.

## Structure
- Shared package/include `uart_defs`:
  - FSM state encodings.
  - `PARITY_NONE/EVEN/ODD` constants.
  - The `BAUD_DIV`/`HALF` derivation, reused by the transmitter.
- One sub-module, `uart_baud_cnt`:
  - Inputs: `clr`, `en`.
  - Outputs: `mid_m1`, `mid`, `mid_p1`, `wrap` strobes.
  - Parameterised by `BAUD_DIV`. Shared with the future configurable transmitter.
- Majority vote, parity calculation and the shift register stay in `uart_rx_cfg`.

## Test plan
- Defaults (`BAUD_DIV`=520), 8N1, send 0x55 → one `po_flag` pulse, `po_data`=0x55, `parity_err`=0, `frame_err`=0, `busy` low afterwards.
- `PARITY_EN`=1, even parity:
  - Send 0xA5 with parity bit 0 → `parity_err`=0.
  - Resend with parity bit 1 → `po_data`=0xA5, `parity_err`=1.
- 8N1, send 0x3C with the stop bit driven low → `po_data`=0x3C, `frame_err`=1. A following 0x81 frame, sent after the line returns high, is received cleanly.
- `rx` pulled low for 100 cycles (< `HALF`) then high → no `po_flag`, `busy` pulses then returns to 0.
- A 1-cycle high glitch at count `HALF` of data bit 0 of 0x00 → majority rejects it, `po_data`=0x00.
- `rst` asserted during data bit 4 → all outputs 0 and no `po_flag`. The next 0xC3 frame after release gives `po_data`=0xC3.
